// File: rtl/reduceron_io_pkg.sv
// Shared constants for the Reduceron IO controller: address map, STATUS layout, sequencer states.
package reduceron_io_pkg;

    localparam logic [2:0] IO_TXDATA = 3'd0;
    localparam logic [2:0] IO_RXDATA = 3'd1;
    localparam logic [2:0] IO_STATUS = 3'd2;
    localparam logic [2:0] IO_LED    = 3'd3;
    localparam logic [2:0] IO_CYC_LO = 3'd4;
    localparam logic [2:0] IO_CYC_HI = 3'd5;

    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_SPACE = 1;
    localparam int ST_ERR      = 2;

    localparam int CYC_W = 30;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DUMP  = 2'd2,
        S_HALT  = 2'd3
    } io_state_e;

endpackage

// File: rtl/io_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO is taken when a pop happens in the same cycle.
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reduceron_io_ctrl.sv
// Memory-mapped IO controller and end-of-run sequencer for the Reduceron core.
//
//   state | meaning
//   RUN   | core running, IO requests serviced, cycle counter advancing
//   DRAIN | core finished, waiting for the TX FIFO to empty
//   DUMP  | pushing the 3 result bytes (MSB first) into the TX FIFO
//   HALT  | all done; halted once the FIFO has drained, core stalled forever
module reduceron_io_ctrl
    import reduceron_io_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int AW       = 15,
    parameter int DW       = 15,
    parameter int RW       = 18
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [AW-1:0] io_addr,
    input  logic          io_write,
    input  logic          io_read,
    input  logic [DW-1:0] io_wdata,
    output logic [DW-1:0] io_rdata,
    output logic          io_wait,
    input  logic          finish,
    input  logic [RW-1:0] result,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [7:0]    led,
    output logic          halted
);

    io_state_e        state_q;
    io_state_e        state_d;
    logic [1:0]       dump_idx_q;
    logic [1:0]       dump_idx_d;
    logic             dump_push;
    logic [7:0]       dump_byte;
    logic [RW-1:0]    result_q;
    logic [CYC_W-1:0] cyc_q;
    logic [7:0]       led_q;
    logic [7:0]       rx_byte_q;
    logic             rx_full_q;
    logic             err_q;
    logic [DW-1:0]    rdata_q;
    logic [DW-1:0]    rd_val;

    logic             addr_ok;
    logic [2:0]       sel;
    logic             wr_req;
    logic             rd_req;
    logic             accept;
    logic             wr_acc;
    logic             rd_acc;
    logic             both_acc;
    logic             rx_load;
    logic             rx_pop;

    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_wdata;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;

    logic             unused_wdata_hi;
    assign unused_wdata_hi = ^io_wdata[DW-1:8];

    // Address decode and handshake. When read and write arrive together the
    // write wins, so a simultaneous RXDATA read never stalls or pops.
    assign addr_ok  = (io_addr[AW-1:3] == '0);
    assign sel      = io_addr[2:0];
    assign wr_req   = io_write & addr_ok;
    assign rd_req   = io_read & ~io_write & addr_ok;
    // finish also stalls so the request present on the finishing cycle is
    // visibly not accepted; the core re-presents it (it will then stall forever).
    assign io_wait  = (wr_req & (sel == IO_TXDATA) & fifo_full)
                    | (rd_req & (sel == IO_RXDATA) & ~rx_full_q)
                    | (state_q != S_RUN)
                    | finish;
    assign accept   = (io_read | io_write) & ~io_wait;
    assign wr_acc   = accept & wr_req;
    assign rd_acc   = accept & io_read & ~io_write;
    assign both_acc = accept & io_read & io_write;

    assign rx_ready = ~rx_full_q;
    assign rx_load  = rx_valid & ~rx_full_q;
    assign rx_pop   = rd_acc & addr_ok & (sel == IO_RXDATA);

    assign io_rdata = rdata_q;
    assign led      = led_q;
    assign tx_data  = fifo_head;
    assign tx_valid = ~fifo_empty;
    assign halted   = (state_q == S_HALT) & fifo_empty;

    assign fifo_pop   = ~fifo_empty & tx_ready;
    assign fifo_push  = dump_push | (wr_acc & (sel == IO_TXDATA));
    assign fifo_wdata = dump_push ? dump_byte : io_wdata[7:0];

    io_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Read data mux; unmapped addresses read as zero.
    always_comb begin
        rd_val = '0;
        if (addr_ok) begin
            case (sel)
                IO_RXDATA: rd_val = DW'(rx_byte_q);
                IO_STATUS: begin
                    rd_val[ST_RX_AVAIL] = rx_full_q;
                    rd_val[ST_TX_SPACE] = ~fifo_full;
                    rd_val[ST_ERR]      = err_q;
                end
                IO_LED:    rd_val = DW'(led_q);
                IO_CYC_LO: rd_val = DW'(cyc_q[14:0]);
                IO_CYC_HI: rd_val = DW'(cyc_q[29:15]);
                default:   rd_val = '0;
            endcase
        end
    end

    // Sequencer next-state and result-byte selection.
    always_comb begin
        state_d    = state_q;
        dump_idx_d = dump_idx_q;
        dump_push  = 1'b0;
        case (dump_idx_q)
            2'd0:    dump_byte = {6'b0, result_q[17:16]};
            2'd1:    dump_byte = result_q[15:8];
            default: dump_byte = result_q[7:0];
        endcase
        case (state_q)
            S_RUN: begin
                if (finish) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d    = S_DUMP;
                    dump_idx_d = 2'd0;
                end
            end
            S_DUMP: begin
                if (!fifo_full) begin
                    dump_push = 1'b1;
                    if (dump_idx_q == 2'd2) begin
                        state_d = S_HALT;
                    end else begin
                        dump_idx_d = dump_idx_q + 2'd1;
                    end
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    // Sequencer state, latched result and free-running cycle counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_RUN;
            dump_idx_q <= 2'd0;
            result_q   <= '0;
            cyc_q      <= '0;
        end else begin
            state_q    <= state_d;
            dump_idx_q <= dump_idx_d;
            if ((state_q == S_RUN) && finish) begin
                result_q <= result;
            end
            if (state_q == S_RUN) begin
                cyc_q <= cyc_q + CYC_W'(1);
            end
        end
    end

    // Register-file side effects: LED, RX holding register, sticky error, read data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            led_q     <= '0;
            rx_byte_q <= '0;
            rx_full_q <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (wr_acc && (sel == IO_LED)) begin
                led_q <= io_wdata[7:0];
            end
            if (rx_pop) begin
                rx_full_q <= 1'b0;
            end
            if (rx_load) begin
                rx_full_q <= 1'b1;
                rx_byte_q <= rx_data;
            end
            if (both_acc) begin
                err_q <= 1'b1;
            end
            if (rd_acc) begin
                rdata_q <= rd_val;
            end
        end
    end

endmodule
